// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, port owner encoding and the default abort timeout.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts memory-wait cycles of one transaction; expired_o flags the last
// permitted wait cycle (count == TIMEOUT-1).
module mem_timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Wait-cycle counter: cleared when a transaction is issued, advanced per unacked cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (enable_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and
// data stages, with per-transaction timeout abort and registered outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_grant_q, last_grant_d;
    owner_e      grant_s;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;
    logic        cnt_clear_s, cnt_en_s, expired_s;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clear_s),
        .enable_i  (cnt_en_s),
        .expired_o (expired_s)
    );

    // Next-state and next-output decode for the IDLE/ISSUE/DONE transaction FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        err_d        = 1'b0;
        cnt_clear_s  = 1'b0;
        cnt_en_s     = 1'b0;
        // On a tie the data port wins unless it had the previous grant.
        grant_s      = (d_req && (!if_req || (last_grant_q == OWN_I))) ? OWN_D : OWN_I;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d      = ST_ISSUE;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    mem_req_d    = 1'b1;
                    cnt_clear_s  = 1'b1;
                    if (grant_s == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = mem_we_q ? 32'd0 : mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (expired_s) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = 32'd0;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    cnt_en_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            err_q        <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign err       = err_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, cycle-exact bench for mem_port_arbiter built with TIMEOUT=4;
// each scenario task drives stimulus and compares against hand-derived values.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (if_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        n_cmp++; if ({if_ready, d_ready, err} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {if_ready, d_ready, err}); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 32'h10;
        #1;
        n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_idle: got %b want 1", stall_if); end
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL fetch_mem_addr: got %h want 10", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_we: got %b want 0", mem_we); end
        step();
        n_cmp++; if (stall_if !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_issue: got %b want 1", stall_if); end
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ready: got %b want 0", if_ready); end
        step();
        n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready: got %b want 1", if_ready); end
        n_cmp++; if (if_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL fetch_rdata: got %h want a5a5a5a5", if_rdata); end
        n_cmp++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_done: got %b want 0", stall_if); end
        n_cmp++; if ({mem_req, err} !== 2'b00) begin n_bad++; $display("FAIL fetch_done_req_err: got %b want 00", {mem_req, err}); end
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        if_req    = 1'b0;
        step();
        n_cmp++; if (if_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_ready_one_cycle: got %b want 0", if_ready); end
        n_cmp++; if (if_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL fetch_rdata_hold: got %h want a5a5a5a5", if_rdata); end
    endtask

    task automatic test_tie_after_reset();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h4;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h20;
        #1;
        n_cmp++; if (stall_mem !== 1'b1) begin n_bad++; $display("FAIL tie_stall_mem: got %b want 1", stall_mem); end
        step();
        n_cmp++; if (mem_addr !== 32'h20) begin n_bad++; $display("FAIL tie_first_addr: got %h want 20", mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h11112222;
        step();
        n_cmp++; if ({d_ready, if_ready} !== 2'b10) begin n_bad++; $display("FAIL tie_first_ready: got %b want 10", {d_ready, if_ready}); end
        n_cmp++; if (d_rdata !== 32'h11112222) begin n_bad++; $display("FAIL tie_d_rdata: got %h want 11112222", d_rdata); end
        d_req   = 1'b0;
        mem_ack = 1'b0;
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL tie_idle_gap: got %b want 0", mem_req); end
        step();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin n_bad++; $display("FAIL tie_second_cmd: got %b/%h want 1/4", mem_req, mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h33334444;
        step();
        n_cmp++; if ({d_ready, if_ready} !== 2'b01) begin n_bad++; $display("FAIL tie_second_ready: got %b want 01", {d_ready, if_ready}); end
        n_cmp++; if (if_rdata !== 32'h33334444) begin n_bad++; $display("FAIL tie_if_rdata: got %h want 33334444", if_rdata); end
        n_cmp++; if (d_rdata !== 32'h11112222) begin n_bad++; $display("FAIL tie_d_rdata_hold: got %h want 11112222", d_rdata); end
        if_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        step();
        step();
        step();
        step();
        n_cmp++; if ({mem_req, d_ready, err} !== 3'b100) begin n_bad++; $display("FAIL to_4th_issue: got %b want 100", {mem_req, d_ready, err}); end
        step();
        n_cmp++; if ({d_ready, err} !== 2'b11) begin n_bad++; $display("FAIL to_ready_err: got %b want 11", {d_ready, err}); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("FAIL to_d_rdata: got %h want 0", d_rdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL to_mem_req: got %b want 0", mem_req); end
        d_req = 1'b0;
        step();
        n_cmp++; if ({d_ready, err} !== 2'b00) begin n_bad++; $display("FAIL to_pulse_end: got %b want 00", {d_ready, err}); end
        d_req  = 1'b1;
        d_addr = 32'h44;
        step();
        step();
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A0F0F;
        step();
        n_cmp++; if ({d_ready, err} !== 2'b10) begin n_bad++; $display("FAIL ackwin_ready_err: got %b want 10", {d_ready, err}); end
        n_cmp++; if (d_rdata !== 32'h5A5A0F0F) begin n_bad++; $display("FAIL ackwin_d_rdata: got %h want 5a5a0f0f", d_rdata); end
        d_req   = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h8;
        d_wdata = 32'hDEADBEEF;
        step();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h8}) begin n_bad++; $display("FAIL st_cmd: got %b%b/%h want 11/8", mem_req, mem_we, mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_wdata: got %h want deadbeef", mem_wdata); end
        step();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h8, 32'hDEADBEEF}) begin n_bad++; $display("FAIL st_cmd_stable: got %b/%h/%h", mem_we, mem_addr, mem_wdata); end
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL st_ready: got %b want 1", d_ready); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("FAIL st_d_rdata: got %h want 0", d_rdata); end
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_wdata = 32'd0;
        mem_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_issue();
        d_req  = 1'b1;
        d_addr = 32'h80;
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_issue: got %b want 1", mem_req); end
        reset = 1'b1;
        step();
        n_cmp++; if ({mem_req, d_ready, err} !== 3'b000) begin n_bad++; $display("FAIL rmid_abort: got %b want 000", {mem_req, d_ready, err}); end
        reset     = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        step();
        n_cmp++; if ({mem_req, d_ready, if_ready, err} !== 4'b0000) begin n_bad++; $display("FAIL rmid_stray_ack: got %b want 0000", {mem_req, d_ready, if_ready, err}); end
        n_cmp++; if (d_rdata !== 32'd0) begin n_bad++; $display("FAIL rmid_d_rdata: got %h want 0", d_rdata); end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        want_d;
        logic [31:0] want_addr;
        reset = 1'b1;
        step();
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        for (int k = 0; k < 4; k++) begin
            want_d    = ((k % 2) == 0);
            want_addr = want_d ? 32'h100 : 32'h200;
            step();
            n_cmp++; if (mem_addr !== want_addr) begin n_bad++; $display("FAIL rr_addr_%0d: got %h want %h", k, mem_addr, want_addr); end
            mem_ack   = 1'b1;
            mem_rdata = 32'h1000 + 32'(k);
            step();
            n_cmp++; if ({d_ready, if_ready} !== {want_d, ~want_d}) begin n_bad++; $display("FAIL rr_ready_%0d: got %b want %b", k, {d_ready, if_ready}, {want_d, ~want_d}); end
            mem_ack = 1'b0;
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;
        test_reset();
        test_fetch();
        test_tie_after_reset();
        test_timeout();
        test_store();
        test_reset_mid_issue();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
